// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the word-addressed PC, reads the combinational
// instruction memory and fills the IF/ID register. Handles boot bubble, stall, flush, redirect and halt.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        pc_src,
   input  logic [31:0] branch_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_npc,
   output logic        if_id_valid,
   output logic        halted,
   output logic [31:0] fetch_count
);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] npc_q, npc_d;
   logic        valid_q, valid_d;
   logic        halted_q, halted_d;
   logic [31:0] count_q, count_d;
   logic [31:0] pc_inc_s;

   assign pc_inc_s = pc_q + 32'd1;

   // Next-state and IF/ID selection; redirect outranks stall and flush in RUN.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      npc_d    = npc_q;
      valid_d  = valid_q;
      halted_d = halted_q;
      count_d  = count_q;
      case (state_q)
         S_BOOT: begin
            instr_d = 32'd0;
            npc_d   = 32'd0;
            valid_d = 1'b0;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (pc_src) begin
               pc_d    = branch_target;
               instr_d = 32'd0;
               npc_d   = 32'd0;
               valid_d = 1'b0;
            end else if (stall && flush) begin
               instr_d = 32'd0;
               npc_d   = 32'd0;
               valid_d = 1'b0;
            end else if (stall) begin
               pc_d = pc_q;
            end else if (flush) begin
               pc_d    = pc_inc_s;
               instr_d = 32'd0;
               npc_d   = 32'd0;
               valid_d = 1'b0;
            end else begin
               instr_d = imem_data;
               npc_d   = pc_inc_s;
               valid_d = 1'b1;
               count_d = count_q + 32'd1;
               // The halt word is latched as a real instruction but the PC stays on it.
               if (imem_data == HALT_WORD) begin
                  state_d  = S_HALT;
                  halted_d = 1'b1;
               end else begin
                  pc_d = pc_inc_s;
               end
            end
         end
         S_HALT: begin
            instr_d  = 32'd0;
            npc_d    = 32'd0;
            valid_d  = 1'b0;
            halted_d = 1'b1;
         end
         default: begin
            state_d  = S_BOOT;
            instr_d  = 32'd0;
            npc_d    = 32'd0;
            valid_d  = 1'b0;
            halted_d = 1'b0;
         end
      endcase
   end

   // State, PC and IF/ID registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_BOOT;
         pc_q     <= RESET_PC;
         instr_q  <= 32'd0;
         npc_q    <= 32'd0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         count_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         npc_q    <= npc_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
         count_q  <= count_d;
      end
   end

   assign imem_addr   = pc_q;
   assign if_id_instr = instr_q;
   assign if_id_npc   = npc_q;
   assign if_id_valid = valid_q;
   assign halted      = halted_q;
   assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: default-PC instance for the main flow and a
// second instance with RESET_PC at the top of the address space for PC wrap.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n, stall, flush, pc_src;
   logic [31:0] branch_target;
   logic [31:0] imem_addr, imem_data, if_id_instr, if_id_npc, fetch_count;
   logic        if_id_valid, halted;

   logic        rst1_n;
   logic [31:0] imem_addr1, imem_data1, if_id_instr1, if_id_npc1, fetch_count1;
   logic        if_id_valid1, halted1;

   logic [64:0] ifid_s, ifid1_s;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      logic [6:0] a;
      a = addr[6:0];
      case (a)
         7'd0:    mem_word = 32'hA000_00AA;
         7'd1:    mem_word = 32'h1000_0011;
         7'd2:    mem_word = 32'h2000_0022;
         7'd3:    mem_word = 32'h3000_0033;
         7'd9:    mem_word = 32'h9000_0099;
         7'd10:   mem_word = 32'hFFFF_FFFF;
         default: mem_word = 32'h0000_0000;
      endcase
   endfunction

   assign imem_data  = mem_word(imem_addr);
   assign imem_data1 = mem_word(imem_addr1);
   assign ifid_s     = {if_id_instr, if_id_npc, if_id_valid};
   assign ifid1_s    = {if_id_instr1, if_id_npc1, if_id_valid1};

   fetch_stage u0 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .pc_src(pc_src),
      .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
      .if_id_instr(if_id_instr), .if_id_npc(if_id_npc), .if_id_valid(if_id_valid),
      .halted(halted), .fetch_count(fetch_count)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFF), .HALT_WORD(32'hFFFF_FFFF)) u1 (
      .clk(clk), .rst_n(rst1_n), .stall(1'b0), .flush(1'b0), .pc_src(1'b0),
      .branch_target(32'd0), .imem_addr(imem_addr1), .imem_data(imem_data1),
      .if_id_instr(if_id_instr1), .if_id_npc(if_id_npc1), .if_id_valid(if_id_valid1),
      .halted(halted1), .fetch_count(fetch_count1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0; pc_src = 1'b0; branch_target = 32'd0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++;
      if ({ifid_s, halted, fetch_count, imem_addr} !== {65'd0, 1'b0, 32'd0, 32'd0})
         $display("FAIL reset: ifid=%h halted=%b count=%0d addr=%h, want all zero",
                  ifid_s, halted, fetch_count, imem_addr);
      else pass_cnt++;
   endtask

   task automatic test_run_free();
      tick();
      total_cnt++;
      if ({ifid_s, imem_addr} !== {65'd0, 32'd0})
         $display("FAIL boot_bubble: ifid=%h addr=%h want bubble, addr 0", ifid_s, imem_addr);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (ifid_s !== {32'hA000_00AA, 32'd1, 1'b1})
         $display("FAIL run_word0: got %h want %h", ifid_s, {32'hA000_00AA, 32'd1, 1'b1});
      else pass_cnt++;
      tick();
      total_cnt++;
      if (ifid_s !== {32'h1000_0011, 32'd2, 1'b1})
         $display("FAIL run_word1: got %h want %h", ifid_s, {32'h1000_0011, 32'd2, 1'b1});
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({ifid_s, fetch_count, imem_addr} !== {32'h2000_0022, 32'd3, 1'b1, 32'd3, 32'd3})
         $display("FAIL run_word2: ifid=%h count=%0d addr=%h want word2 npc3, count 3, addr 3",
                  ifid_s, fetch_count, imem_addr);
      else pass_cnt++;
   endtask

   task automatic test_stall();
      do_reset();
      tick(); tick(); tick();
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         total_cnt++;
         if ({ifid_s, imem_addr} !== {32'h1000_0011, 32'd2, 1'b1, 32'd2})
            $display("FAIL stall_hold%0d: ifid=%h addr=%h want 10000011 npc2, addr 2",
                     i, ifid_s, imem_addr);
         else pass_cnt++;
      end
      stall = 1'b0;
      tick();
      total_cnt++;
      if (ifid_s !== {32'h2000_0022, 32'd3, 1'b1})
         $display("FAIL stall_release: got %h want %h", ifid_s, {32'h2000_0022, 32'd3, 1'b1});
      else pass_cnt++;
   endtask

   task automatic test_branch_halt();
      pc_src = 1'b1; branch_target = 32'd9; stall = 1'b1;
      tick();
      pc_src = 1'b0; stall = 1'b0;
      total_cnt++;
      if ({ifid_s, imem_addr} !== {65'd0, 32'd9})
         $display("FAIL branch_bubble: ifid=%h addr=%h want bubble, addr 9", ifid_s, imem_addr);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({ifid_s, halted} !== {32'h9000_0099, 32'd10, 1'b1, 1'b0})
         $display("FAIL branch_target_word: ifid=%h halted=%b want 90000099 npc10, halted 0",
                  ifid_s, halted);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({ifid_s, halted, imem_addr, fetch_count} !== {32'hFFFF_FFFF, 32'd11, 1'b1, 1'b1, 32'd10, 32'd5})
         $display("FAIL halt_latch: ifid=%h halted=%b addr=%h count=%0d want FFFFFFFF npc11 v1, 1, 10, 5",
                  ifid_s, halted, imem_addr, fetch_count);
      else pass_cnt++;
   endtask

   task automatic test_halt_ignore();
      pc_src = 1'b1; branch_target = 32'd0; flush = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         total_cnt++;
         if ({ifid_s, halted, imem_addr, fetch_count} !== {65'd0, 1'b1, 32'd10, 32'd5})
            $display("FAIL halt_ignore%0d: ifid=%h halted=%b addr=%h count=%0d want bubble, 1, 10, 5",
                     i, ifid_s, halted, imem_addr, fetch_count);
         else pass_cnt++;
      end
      do_reset();
      total_cnt++;
      if ({ifid_s, halted, fetch_count, imem_addr} !== {65'd0, 1'b0, 32'd0, 32'd0})
         $display("FAIL halt_reset: ifid=%h halted=%b count=%0d addr=%h want all zero",
                  ifid_s, halted, fetch_count, imem_addr);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (ifid_s !== 65'd0)
         $display("FAIL reboot_bubble: got %h want bubble", ifid_s);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (ifid_s !== {32'hA000_00AA, 32'd1, 1'b1})
         $display("FAIL reboot_word0: got %h want %h", ifid_s, {32'hA000_00AA, 32'd1, 1'b1});
      else pass_cnt++;
   endtask

   task automatic test_flush();
      tick(); tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      total_cnt++;
      if ({ifid_s, imem_addr, fetch_count} !== {65'd0, 32'd4, 32'd3})
         $display("FAIL flush_word3: ifid=%h addr=%h count=%0d want bubble, addr 4, count 3",
                  ifid_s, imem_addr, fetch_count);
      else pass_cnt++;
      pc_src = 1'b1; branch_target = 32'd10;
      tick();
      pc_src = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      total_cnt++;
      if ({ifid_s, halted, imem_addr} !== {65'd0, 1'b0, 32'd11})
         $display("FAIL flush_halt_word: ifid=%h halted=%b addr=%h want bubble, 0, 11",
                  ifid_s, halted, imem_addr);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({ifid_s, halted} !== {32'd0, 32'd12, 1'b1, 1'b0})
         $display("FAIL after_flush_halt: ifid=%h halted=%b want 0 npc12 v1, 0", ifid_s, halted);
      else pass_cnt++;
      pc_src = 1'b1; branch_target = 32'd10;
      tick();
      pc_src = 1'b0; stall = 1'b1; flush = 1'b1;
      tick();
      stall = 1'b0; flush = 1'b0;
      total_cnt++;
      if ({ifid_s, halted, imem_addr} !== {65'd0, 1'b0, 32'd10})
         $display("FAIL stall_flush_halt_word: ifid=%h halted=%b addr=%h want bubble, 0, 10",
                  ifid_s, halted, imem_addr);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({ifid_s, halted} !== {32'hFFFF_FFFF, 32'd11, 1'b1, 1'b1})
         $display("FAIL halt_after_release: ifid=%h halted=%b want FFFFFFFF npc11 v1, 1", ifid_s, halted);
      else pass_cnt++;
   endtask

   task automatic test_pc_wrap();
      rst1_n = 1'b0;
      tick();
      rst1_n = 1'b1;
      total_cnt++;
      if ({ifid1_s, imem_addr1} !== {65'd0, 32'hFFFF_FFFF})
         $display("FAIL wrap_reset: ifid=%h addr=%h want bubble, FFFFFFFF", ifid1_s, imem_addr1);
      else pass_cnt++;
      tick(); tick();
      total_cnt++;
      if ({ifid1_s, imem_addr1, fetch_count1} !== {32'd0, 32'd0, 1'b1, 32'd0, 32'd1})
         $display("FAIL wrap_first: ifid=%h addr=%h count=%0d want 0 npc0 v1, addr 0, count 1",
                  ifid1_s, imem_addr1, fetch_count1);
      else pass_cnt++;
   endtask

   initial begin
      rst1_n = 1'b0;
      test_reset();
      test_run_free();
      test_stall();
      test_branch_halt();
      test_halt_ignore();
      test_flush();
      test_pc_wrap();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
